// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes and the mul/div sequencer state type.
// MULDIV_DIV_EN adds the DIV state; without it the encoding has no divide state.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int unsigned MD_CNT_W = 5;
  localparam logic [MD_CNT_W-1:0] MD_CNT_LAST = 5'd31;

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DIV  = 2'd3
  } muldiv_state_t;
`else
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_t;
`endif

  // Magnitude of a 32-bit value when treated as signed, raw value otherwise.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add multiply or restoring divide.
// The divide path and its op select only exist when MULDIV_DIV_EN is defined.
module muldiv_step (
`ifdef MULDIV_DIV_EN
  input  logic        op_div,
`endif
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] rem_sh;
  logic [32:0] diff;
`endif

  // Multiply: acc = {partial product, unconsumed multiplier bits}, LSB first.
  // Divide:   acc = {partial remainder, remaining dividend bits / quotient}.
  always_comb begin
    sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
    acc_o = {sum, acc_i[31:1]};
`ifdef MULDIV_DIV_EN
    // Remainder stays below the divisor, so the shifted value fits in 33 bits
    // and diff[32] is a clean borrow flag.
    rem_sh = {acc_i[63:32], acc_i[31]};
    diff   = rem_sh - {1'b0, operand_i};
    if (op_div) begin
      if (diff[32]) acc_o = {rem_sh[31:0], acc_i[30:0], 1'b0};
      else          acc_o = {diff[31:0],   acc_i[30:0], 1'b1};
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise only MULT/MULTU, MT*, MF*.
module ex_muldiv
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IDataA,
  input  logic [31:0] IDataB,
  input  logic [5:0]  IFunct,
  input  logic        IRType,
  output logic        OStall,
  output logic        OBusy,
  output logic [31:0] OHi,
  output logic [31:0] OLo,
  output logic [31:0] OMfData,
  output logic        OMfValid
);

  muldiv_state_t         state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]           acc_q, acc_d;
  logic [31:0]           opnd_q, opnd_d;
  logic                  neg_lo_q, neg_lo_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
`ifdef MULDIV_DIV_EN
  logic                  neg_hi_q, neg_hi_d;
  logic                  div_q, div_d;
  logic                  div_req;
`endif

  logic        mul_req;
  logic        md_req;
  logic        op_signed;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [63:0] step_acc;
  logic [63:0] prod_fix;
  logic        is_mfhi, is_mflo;

  always_comb begin
    op_signed = (IFunct == FUNCT_MULT) || (IFunct == FUNCT_DIV);
    sign_a    = op_signed && IDataA[31];
    sign_b    = op_signed && IDataB[31];
    mag_a     = md_mag(IDataA, op_signed);
    mag_b     = md_mag(IDataB, op_signed);
    mul_req   = IRType && ((IFunct == FUNCT_MULT) || (IFunct == FUNCT_MULTU));
`ifdef MULDIV_DIV_EN
    div_req   = IRType && ((IFunct == FUNCT_DIV) || (IFunct == FUNCT_DIVU));
    md_req    = mul_req || div_req;
`else
    md_req    = mul_req;
`endif
    is_mfhi   = IRType && (IFunct == FUNCT_MFHI);
    is_mflo   = IRType && (IFunct == FUNCT_MFLO);
  end

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .op_div    (state_q == MD_DIV),
`endif
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULDIV_DIV_EN
    neg_hi_d = neg_hi_q;
    div_d    = div_q;
`endif
    prod_fix = neg_lo_q ? -acc_q : acc_q;

    case (state_q)
      MD_IDLE: begin
        if (mul_req) begin
          state_d  = MD_MUL;
          cnt_d    = '0;
          acc_d    = {32'd0, mag_b};
          opnd_d   = mag_a;
          neg_lo_d = sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
          div_d    = 1'b0;
        end else if (div_req) begin
          state_d  = MD_DIV;
          cnt_d    = '0;
          acc_d    = {32'd0, mag_a};
          opnd_d   = mag_b;
          // A zero divisor leaves the all-ones quotient unsigned, and the
          // sign-restored remainder then equals rs.
          neg_lo_d = (sign_a ^ sign_b) && (IDataB != 32'd0);
          neg_hi_d = sign_a;
          div_d    = 1'b1;
`endif
        end else if (IRType && (IFunct == FUNCT_MTHI)) begin
          hi_d = IDataA;
        end else if (IRType && (IFunct == FUNCT_MTLO)) begin
          lo_d = IDataA;
        end
      end
      MD_MUL: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MD_CNT_LAST) state_d = MD_FIX;
      end
`ifdef MULDIV_DIV_EN
      MD_DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MD_CNT_LAST) state_d = MD_FIX;
      end
`endif
      MD_FIX: begin
        // The finished instruction is still in EX here, so no request is taken.
        state_d = MD_IDLE;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          lo_d = neg_lo_q ? -acc_q[31:0]  : acc_q[31:0];
          hi_d = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
`else
        {hi_d, lo_d} = prod_fix;
`endif
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_DIV_EN
      neg_hi_q <= 1'b0;
      div_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
      neg_hi_q <= neg_hi_d;
      div_q    <= div_d;
`endif
    end
  end

  always_comb begin
    OStall   = ((state_q == MD_IDLE) && md_req) || (state_q == MD_MUL);
`ifdef MULDIV_DIV_EN
    OStall   = OStall || (state_q == MD_DIV);
`endif
    OBusy    = (state_q != MD_IDLE);
    OHi      = hi_q;
    OLo      = lo_q;
    OMfValid = is_mfhi || is_mflo;
    OMfData  = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv; expectations follow the MULDIV_DIV_EN setting.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ex_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IDataA, IDataB;
  logic [5:0]  IFunct;
  logic        IRType;
  logic        OStall, OBusy, OMfValid;
  logic [31:0] OHi, OLo, OMfData;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk      (clk),
    .reset    (reset),
    .IDataA   (IDataA),
    .IDataB   (IDataB),
    .IFunct   (IFunct),
    .IRType   (IRType),
    .OStall   (OStall),
    .OBusy    (OBusy),
    .OHi      (OHi),
    .OLo      (OLo),
    .OMfData  (OMfData),
    .OMfValid (OMfValid)
  );

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    int          stall;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic rt);
    IFunct = f;
    IDataA = a;
    IDataB = b;
    IRType = rt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int stall,
                       input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.stall = stall;
    e.hi    = hi;
    e.lo    = lo;
    e.tag   = tag;
    drive(f, a, b, 1'b1);
    sb.push_back(e);
    model_hi = hi;
    model_lo = lo;
  endtask

  // Divide expectations: real results when the divider exists, else a no-op.
  task automatic issue_div(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    if (DIV_EN) issue(tag, f, a, b, 33, hi, lo);
    else        issue(tag, f, a, b, 0, model_hi, model_lo);
  endtask

  // Called on the falling edge of the acceptance cycle; returns 1ns after the
  // rising edge that ends the instruction's last EX cycle.
  task automatic wait_done();
    int n = 0;
    check("sb_pending", 64'(sb.size() > 0), 64'd1);
    if (sb.size() == 0) return;
    cur = sb.pop_front();
    while (OStall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({cur.tag, "_stall_cycles"}, 64'(n), 64'(cur.stall));
    if (n > 0) begin
      check({cur.tag, "_busy_in_fix"}, 64'(OBusy), 64'd1);
      check({cur.tag, "_mfvalid_low"}, 64'(OMfValid), 64'd0);
    end
    next_cycle();
  endtask

  task automatic check_result();
    check({cur.tag, "_hi"}, 64'(OHi), 64'(cur.hi));
    check({cur.tag, "_lo"}, 64'(OLo), 64'(cur.lo));
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int stall,
                        input logic [31:0] hi, input logic [31:0] lo);
    issue(tag, f, a, b, stall, hi, lo);
    @(negedge clk);
    wait_done();
    drive(6'h00, '0, '0, 1'b0);
    @(negedge clk);
    check_result();
    check({tag, "_idle_after"}, 64'(OBusy), 64'd0);
    next_cycle();
  endtask

  task automatic run_div(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    issue_div(tag, f, a, b, hi, lo);
    @(negedge clk);
    wait_done();
    drive(6'h00, '0, '0, 1'b0);
    @(negedge clk);
    check_result();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(6'h00, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(OStall), 64'd0);
    check("rst_busy",  64'(OBusy),  64'd0);
    check("rst_hi",    64'(OHi),    64'd0);
    check("rst_lo",    64'(OLo),    64'd0);
    next_cycle();
    reset = 1'b0;

    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);

    // MULT followed directly by MFLO
    issue("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);
    wait_done();
    drive(FUNCT_MFLO, '0, '0, 1'b1);
    @(negedge clk);
    check_result();
    check("mflo_after_mult_data",  64'(OMfData),  64'hFFFF_FFEB);
    check("mflo_after_mult_valid", 64'(OMfValid), 64'd1);
    check("mflo_after_mult_stall", 64'(OStall),   64'd0);
    next_cycle();

    // Back-to-back multiplies: the second is accepted right after FIX
    issue("b2b_first", FUNCT_MULTU, 32'd6, 32'd7, 33, 32'd0, 32'd42);
    @(negedge clk);
    wait_done();
    issue("b2b_second", FUNCT_MULT, 32'h8000_0000, 32'd2, 33, 32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk);
    check_result();
    check("b2b_accept_stall", 64'(OStall), 64'd1);
    wait_done();
    drive(6'h00, '0, '0, 1'b0);
    @(negedge clk);
    check_result();
    next_cycle();

    run_div("div_neg",     FUNCT_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("divu_by0",    FUNCT_DIVU, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
    run_div("div_ovf",     FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_div("divu_9_2",    FUNCT_DIVU, 32'd9,         32'd2,         32'd1,         32'd4);

    // MTHI/MTLO followed by the matching move-from
    drive(FUNCT_MTHI, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("mthi_stall", 64'(OStall), 64'd0);
    next_cycle();
    drive(FUNCT_MFHI, '0, '0, 1'b1);
    @(negedge clk);
    check("mfhi_data",  64'(OMfData),  64'h0000_1234);
    check("mfhi_valid", 64'(OMfValid), 64'd1);
    check("mfhi_stall", 64'(OStall),   64'd0);
    next_cycle();
    drive(FUNCT_MTLO, 32'h0000_5678, '0, 1'b1);
    next_cycle();
    drive(FUNCT_MFLO, '0, '0, 1'b1);
    @(negedge clk);
    check("mflo_data", 64'(OMfData), 64'h0000_5678);
    check("mt_hi_kept", 64'(OHi), 64'h0000_1234);
    model_hi = 32'h0000_1234;
    model_lo = 32'h0000_5678;
    next_cycle();

    // Non-R-type with a MULT funct and flushed MFHI are both ignored
    drive(FUNCT_MULT, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    check("nonr_stall",    64'(OStall),   64'd0);
    check("nonr_mfvalid",  64'(OMfValid), 64'd0);
    next_cycle();
    drive(FUNCT_MFHI, '0, '0, 1'b0);
    @(negedge clk);
    check("nonr_busy",   64'(OBusy),   64'd0);
    check("nonr_mfdata", 64'(OMfData), 64'd0);
    check("nonr_hi",     64'(OHi),     64'(model_hi));
    check("nonr_lo",     64'(OLo),     64'(model_lo));
    next_cycle();

    // Reset in the middle of a multiply
    drive(FUNCT_MULTU, 32'h0000_DEAD, 32'h0000_BEEF, 1'b1);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("midrst_pre_stall", 64'(OStall), 64'd1);
    reset = 1'b1;
    drive(6'h00, '0, '0, 1'b0);
    @(negedge clk);
    check("midrst_stall", 64'(OStall), 64'd0);
    check("midrst_busy",  64'(OBusy),  64'd0);
    check("midrst_hi",    64'(OHi),    64'd0);
    check("midrst_lo",    64'(OLo),    64'd0);
    next_cycle();
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;

    run_op("multu_3x5", FUNCT_MULTU, 32'd3, 32'd5, 33, 32'd0, 32'd15);
    run_div("divu_nodiv", FUNCT_DIVU, 32'd9, 32'd2, 32'd1, 32'd4);
    run_op("multu_6x7", FUNCT_MULTU, 32'd6, 32'd7, 33, 32'd0, 32'd42);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
